// File: rtl/seqsum_pkg.sv
// Shared types and default widths for the arithmetic-sequence summer.
package seqsum_pkg;

  localparam int unsigned W_DEF  = 32;
  localparam int unsigned YW_DEF = 64;
  localparam int unsigned CW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seqsum_term_gen.sv
// Current-term register plus the W+1-bit next-term adder and end-of-run compare.
module seqsum_term_gen #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         adv,
  input  logic [W-1:0] a,
  input  logic [W-1:0] bound,
  input  logic [W-1:0] step,
  output logic [W-1:0] term,
  output logic         last_c
);

  logic [W:0] next_sum;

  // The carry bit counts as exceeding the bound, so a wrapping term always terminates.
  assign next_sum = (W+1)'(term) + (W+1)'(step);
  assign last_c   = next_sum > (W+1)'(bound);

  always_ff @(posedge clk) begin
    if (rst) begin
      term <= '0;
    end else if (load) begin
      term <= a;
    end else if (adv) begin
      term <= next_sum[W-1:0];
    end
  end

endmodule

// File: rtl/seqsum_step.sv
// Sums a, a+step, ... up to the inclusive bound b, one term per clock.
module seqsum_step
  import seqsum_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned YW = YW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  step,
  output logic          busy,
  output logic          done,
  output logic [YW-1:0] y,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          err
);

  state_t        state, state_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  step_q, step_d;
  logic [YW-1:0] y_d;
  logic [CW-1:0] count_d;
  logic          ovf_d, err_d, busy_d, done_d;
  logic          load, adv, last_c;
  logic [W-1:0]  term;
  logic [YW:0]   acc_sum;

  seqsum_term_gen #(.W(W)) u_term_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .adv    (adv),
    .a      (a),
    .bound  (b_q),
    .step   (step_q),
    .term   (term),
    .last_c (last_c)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state;
    b_d     = b_q;
    step_d  = step_q;
    y_d     = y;
    count_d = count;
    ovf_d   = ovf;
    err_d   = err;
    load    = 1'b0;
    adv     = 1'b0;
    acc_sum = (YW+1)'(y) + (YW+1)'(term);

    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          b_d     = b;
          step_d  = step;
          y_d     = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          err_d   = (step == '0);
          state_d = (step != '0 && a <= b) ? RUN : DONE;
        end
      end
      RUN: begin
        adv     = 1'b1;
        y_d     = acc_sum[YW-1:0];
        ovf_d   = ovf | acc_sum[YW];
        count_d = count + CW'(1);
        if (last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      b_q    <= '0;
      step_q <= '0;
      y      <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      b_q    <= b_d;
      step_q <= step_d;
      y      <= y_d;
      count  <= count_d;
      ovf    <= ovf_d;
      err    <= err_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_seqsum_step.sv
// Scoreboard bench: drivers queue expected results, monitors check on each done pulse.
module tb_seqsum_step;

  typedef struct {
    logic [63:0] y;
    logic [31:0] count;
    logic        ovf;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Default-parameter instance
  logic        rst0 = 1'b1, st0 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, s0 = '0;
  logic        busy0, done0, ovf0, err0;
  logic [63:0] y0;
  logic [31:0] c0;

  seqsum_step u_dut0 (
    .clk(clk), .rst(rst0), .start(st0), .a(a0), .b(b0), .step(s0),
    .busy(busy0), .done(done0), .y(y0), .count(c0), .ovf(ovf0), .err(err0)
  );

  // Narrow instance for wrap and overflow corners
  logic       rst1 = 1'b1, st1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, s1 = '0;
  logic       busy1, done1, ovf1, err1;
  logic [7:0] y1, c1;

  seqsum_step #(.W(8), .YW(8), .CW(8)) u_dut1 (
    .clk(clk), .rst(rst1), .start(st1), .a(a1), .b(b1), .step(s1),
    .busy(busy1), .done(done1), .y(y1), .count(c1), .ovf(ovf1), .err(err1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per done pulse, then confirm results hold a cycle later.
  exp_t m0, m1;
  bit   hold0 = 0, hold1 = 0;

  always @(negedge clk) begin
    if (hold0) begin
      hold0 = 0;
      chk("d0 hold done", 64'(done0), 64'd0);
      chk("d0 hold y", y0, m0.y);
    end
    if (done0) begin
      if (q0.size() == 0) begin
        chk("d0 unexpected done", 64'(done0), 64'd0);
      end else begin
        m0 = q0.pop_front();
        chk("d0 y", y0, m0.y);
        chk("d0 count", 64'(c0), 64'(m0.count));
        chk("d0 ovf", 64'(ovf0), 64'(m0.ovf));
        chk("d0 err", 64'(err0), 64'(m0.err));
        chk("d0 latency", 64'(cyc), 64'(m0.cyc));
        chk("d0 busy", 64'(busy0), 64'd1);
        hold0 = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (hold1) begin
      hold1 = 0;
      chk("d1 hold done", 64'(done1), 64'd0);
      chk("d1 hold y", 64'(y1), m1.y);
    end
    if (done1) begin
      if (q1.size() == 0) begin
        chk("d1 unexpected done", 64'(done1), 64'd0);
      end else begin
        m1 = q1.pop_front();
        chk("d1 y", 64'(y1), m1.y);
        chk("d1 count", 64'(c1), 64'(m1.count));
        chk("d1 ovf", 64'(ovf1), 64'(m1.ovf));
        chk("d1 err", 64'(err1), 64'(m1.err));
        chk("d1 latency", 64'(cyc), 64'(m1.cyc));
        hold1 = 1;
      end
    end
  end

  task automatic go0(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                     input bit push, input logic [63:0] ey, input logic [31:0] ec,
                     input logic eovf, input logic eerr, input int n);
    exp_t e;
    @(negedge clk);
    a0 = a; b0 = b; s0 = s; st0 = 1'b1;
    @(posedge clk);
    #1;
    st0 = 1'b0;
    if (push) begin
      e.y = ey; e.count = ec; e.ovf = eovf; e.err = eerr; e.cyc = cyc + n;
      q0.push_back(e);
    end
  endtask

  task automatic go1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                     input logic [7:0] ey, input logic [7:0] ec,
                     input logic eovf, input logic eerr, input int n);
    exp_t e;
    @(negedge clk);
    a1 = a; b1 = b; s1 = s; st1 = 1'b1;
    @(posedge clk);
    #1;
    st1 = 1'b0;
    e.y = 64'(ey); e.count = 32'(ec); e.ovf = eovf; e.err = eerr; e.cyc = cyc + n;
    q1.push_back(e);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) chk({name, " timeout"}, 64'd1, 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(busy0), 64'd0);
    chk("reset done", 64'(done0), 64'd0);
    chk("reset y", y0, 64'd0);
    chk("reset count", 64'(c0), 64'd0);

    // Default width: normal, empty, error, single term, term-carry cases
    go0(32'd1, 32'd10, 32'd2, 1, 64'd25, 32'd5, 1'b0, 1'b0, 5);
    drain("d0 basic");
    go0(32'd7, 32'd3, 32'd1, 1, 64'd0, 32'd0, 1'b0, 1'b0, 0);
    drain("d0 empty");
    go0(32'd5, 32'd9, 32'd0, 1, 64'd0, 32'd0, 1'b0, 1'b1, 0);
    drain("d0 err");
    go0(32'd3, 32'd3, 32'd5, 1, 64'd3, 32'd1, 1'b0, 1'b0, 1);
    drain("d0 single");
    go0(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd8, 1, 64'h1_FFFF_FFE8, 32'd2, 1'b0, 1'b0, 2);
    drain("d0 carry");

    // Narrow width: wrap termination, overflow, count wrap
    go1(8'd250, 8'd255, 8'd10, 8'd250, 8'd1, 1'b0, 1'b0, 1);
    drain("d1 wrap");
    go1(8'd200, 8'd255, 8'd50, 8'd194, 8'd2, 1'b1, 1'b0, 2);
    drain("d1 ovf");
    go1(8'd0, 8'd4, 8'd1, 8'd10, 8'd5, 1'b0, 1'b0, 5);
    drain("d1 small");
    go1(8'd0, 8'd255, 8'd1, 8'd128, 8'd0, 1'b1, 1'b0, 256);
    drain("d1 count wrap");

    // Start re-pulsed during RUN is ignored
    go0(32'd1, 32'd10, 32'd2, 1, 64'd25, 32'd5, 1'b0, 1'b0, 5);
    @(negedge clk);
    a0 = 32'd0; b0 = 32'd100; s0 = 32'd1; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    chk("repulse busy", 64'(busy0), 64'd1);
    drain("d0 repulse");

    // Reset mid-RUN abandons the operation without a done pulse
    go0(32'd1, 32'd10, 32'd2, 0, 64'd0, 32'd0, 1'b0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk("midrst busy", 64'(busy0), 64'd0);
    chk("midrst done", 64'(done0), 64'd0);
    chk("midrst y", y0, 64'd0);
    chk("midrst count", 64'(c0), 64'd0);
    chk("midrst ovf", 64'(ovf0), 64'd0);
    chk("midrst err", 64'(err0), 64'd0);
    repeat (10) @(negedge clk);
    go0(32'd1, 32'd10, 32'd2, 1, 64'd25, 32'd5, 1'b0, 1'b0, 5);
    drain("d0 after rst");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seqsum_step.md
SEQSUM_STEP -- requirements
Module: seqsum_step

Interface
REQ-001 SHALL have parameter W, default 32: operand width (a, b, step), unsigned.
REQ-002 SHALL have parameter YW, default 64: accumulator/result width, YW >= W.
REQ-003 SHALL have parameter CW, default 32: term-count width.
REQ-004 SHALL have port clk  input  1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1: request a sum; accepted only in IDLE.
REQ-007 SHALL have port a  input  W: first term.
REQ-008 SHALL have port b  input  W: inclusive upper bound.
REQ-009 SHALL have port step  input  W: increment between terms.
REQ-010 SHALL have port busy  output  1: high in RUN and DONE.
REQ-011 SHALL have port done  output  1: one-cycle completion pulse.
REQ-012 SHALL have port y  output  YW: sum of a, a+step, ... <= b.
REQ-013 SHALL have port count  output  CW: number of terms summed.
REQ-014 SHALL have port ovf  output  1: sum exceeded YW bits, sticky per operation.
REQ-015 SHALL have port err  output  1: step==0 rejected, sticky per operation.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-017 SHALL, on an edge with state IDLE and start=1, latch a/b/step, set term<=a, and clear y, count, ovf and err to 0.
REQ-018 SHALL, at that edge, go to RUN if step!=0 and a<=b; otherwise go to DONE, with err<=1 when step==0.
REQ-019 SHALL, per RUN edge, do y<=y+term (mod 2^YW), count<=count+1 and term<=term+step.
REQ-020 SHALL compute term+step at W+1 bits; result > b (including carry-out) ends the run: state<=DONE on that edge.
REQ-021 SHALL set ovf<=1 on any RUN addition with carry out of YW bits; y wraps modulo 2^YW.
REQ-022 SHALL hold done=1 for exactly the one cycle in DONE, then go to IDLE.
REQ-023 SHALL give latency: start accepted at edge k with N terms puts done high in the cycle after edge k+N (N=0 for empty or error).
REQ-024 SHALL hold y, count, ovf and err stable from done until the next accepted start.
REQ-025 SHALL ignore start while busy: no relatch, no restart.
REQ-026 SHALL let count wrap modulo 2^CW; the sum is unaffected.

Reset
REQ-027 SHALL, with rst=1 at an edge, force IDLE and busy=done=ovf=err=0, y=0, count=0, overriding any other action that cycle.
REQ-028 SHALL, on reset mid-RUN, abandon the operation; no done pulse is produced.

Structure
REQ-029 SHALL place the state enum and default W/YW/CW constants in shared package seqsum_pkg.
REQ-030 SHALL use one sub-module, seqsum_term_gen, holding the term register, W+1-bit next-term adder and the termination compare.

Verification
REQ-031 SHALL cover default parameters, a=1, b=10, step=2 -> done after 5 RUN edges; y=25, count=5, ovf=0, err=0.
REQ-032 SHALL cover a=7, b=3, step=1 -> done in the cycle after the start edge; y=0, count=0.
REQ-033 SHALL cover a=5, b=9, step=0 -> immediate done; err=1, y=0, count=0.
REQ-034 SHALL cover W=8, YW=8, a=250, b=255, step=10 -> the term wraps and is terminated; y=250, count=1, ovf=0.
REQ-035 SHALL cover W=8, YW=8, a=200, b=255, step=50 -> y=194 (450 mod 256), count=2, ovf=1.
REQ-036 SHALL cover start re-pulsed during RUN, and rst=1 for one cycle mid-RUN -> the first is ignored; reset clears all outputs with no done, then a fresh start with a=1, b=10, step=2 returns y=25.
